// File: rtl/uart_pkg.sv
// Shared UART receiver types, divider computation and parameter legality checks.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_FRAME,
    ERR_PARITY,
    ERR_OVERRUN
  } rx_err_t;

  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic bit uart_cfg_ok(input int os, input int data_bits,
                                     input int depth, input int div);
    return (os >= 4) && (os % 2 == 0) && (data_bits >= 5) && (data_bits <= 8) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0) && (div >= 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; push while full succeeds
// only when a pop happens in the same cycle, push while empty never bypasses.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en && (count != '0);
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with error reporting and a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit (type selected by PARITY_ODD_I).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_I,
  input  logic                          RSTN_I,
  input  logic                          RX_I,
`ifdef UART_RX_PARITY_EN
  input  logic                          PARITY_ODD_I,
`endif
  output logic [DATA_BITS-1:0]          DAT_O,
  output logic                          VALID_O,
  input  logic                          READY_I,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL_O,
  output logic                          FRAME_ERR_O,
  output logic                          PARITY_ERR_O,
  output logic                          OVERRUN_O
);
  localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_BITS);

  if (!uart_cfg_ok(OVERSAMPLE, DATA_BITS, FIFO_DEPTH, DIV)) begin : g_cfg_err
    $error("uart_rx: illegal parameter combination");
  end

  logic [1:0]           sync_q;
  logic                 rxs;
  logic [DW-1:0]        div_cnt;
  logic                 tick, last;
  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  rx_err_t              err_q, err_n;
  logic                 push_req, fifo_full, pop;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_n;
`endif

  assign rxs  = sync_q[1];
  assign tick = (div_cnt == DW'(DIV - 1));
  assign last = tick && (cnt == CW'(OVERSAMPLE - 1));
  assign pop  = VALID_O && READY_I;

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      sync_q    <= '1;
      div_cnt   <= '0;
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      err_q     <= ERR_NONE;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], RX_I};
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      err_q     <= err_n;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    sh_n      = sh;
    err_n     = ERR_NONE;
    push_req  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n = par_err_q;
`endif
    if (tick && state != ST_IDLE && state != ST_BREAK) cnt_n = last ? '0 : cnt + 1'b1;
    case (state)
      ST_IDLE: if (tick && !rxs) begin
        state_n = ST_START;
        cnt_n   = '0;
      end
      ST_START: if (tick && cnt == CW'(OVERSAMPLE/2 - 1)) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (last) begin
        sh_n  = {rxs, sh[DATA_BITS-1:1]};
        idx_n = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (idx == IW'(DATA_BITS - 1)) state_n = ST_PARITY;
`else
        if (idx == IW'(DATA_BITS - 1)) state_n = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (last) begin
        par_err_n = (rxs != ((^sh) ^ PARITY_ODD_I));
        state_n   = ST_STOP;
      end
`endif
      ST_STOP: if (last) begin
        if (rxs) begin
          state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          if (par_err_q) err_n = ERR_PARITY;
          else begin
`else
          begin
`endif
            push_req = 1'b1;
            // A simultaneous pop frees the slot, so a full FIFO still accepts.
            if (fifo_full && !pop) err_n = ERR_OVERRUN;
          end
        end else begin
          err_n   = ERR_FRAME;
          state_n = ST_BREAK;
        end
      end
      ST_BREAK: if (tick && rxs) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK_I),
    .rst_n   (RSTN_I),
    .wr_en   (push_req),
    .wr_data (sh),
    .rd_en   (READY_I),
    .rd_data (DAT_O),
    .full    (fifo_full),
    .count   (LEVEL_O)
  );

  assign VALID_O     = (LEVEL_O != '0);
  assign FRAME_ERR_O = (err_q == ERR_FRAME);
  assign OVERRUN_O   = (err_q == ERR_OVERRUN);
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR_O = (err_q == ERR_PARITY);
`else
  assign PARITY_ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 18.432 MHz / 115200 baud / x16 (160 clocks per bit).
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int BIT   = 160;
  localparam int FRAME = 11 * BIT;

  logic       CLK_I = 1'b0;
  logic       RSTN_I, RX_I, READY_I;
`ifdef UART_RX_PARITY_EN
  logic       PARITY_ODD_I;
`endif
  logic [7:0] DAT_O;
  logic       VALID_O;
  logic [4:0] LEVEL_O;
  logic       FRAME_ERR_O, PARITY_ERR_O, OVERRUN_O;

  always #5 CLK_I = ~CLK_I;

  uart_rx #(
    .CLK_HZ     (18_432_000),
    .BAUD       (115200),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .FIFO_DEPTH (16)
  ) dut (
    .CLK_I        (CLK_I),
    .RSTN_I       (RSTN_I),
    .RX_I         (RX_I),
`ifdef UART_RX_PARITY_EN
    .PARITY_ODD_I (PARITY_ODD_I),
`endif
    .DAT_O        (DAT_O),
    .VALID_O      (VALID_O),
    .READY_I      (READY_I),
    .LEVEL_O      (LEVEL_O),
    .FRAME_ERR_O  (FRAME_ERR_O),
    .PARITY_ERR_O (PARITY_ERR_O),
    .OVERRUN_O    (OVERRUN_O)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         err_exp[$];   // 1 frame, 2 parity, 3 overrun

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected characters on each handshake and expected error kinds on each pulse.
  always @(negedge CLK_I) begin
    int code, n;
    if (RSTN_I) begin
      if (VALID_O && READY_I) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_char: got 0x%0h expected none", DAT_O);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (DAT_O !== e) begin
            errors++;
            $display("FAIL rx_data: got 0x%0h expected 0x%0h", DAT_O, e);
          end
        end
      end
      n    = int'(FRAME_ERR_O) + int'(PARITY_ERR_O) + int'(OVERRUN_O);
      code = FRAME_ERR_O ? 1 : PARITY_ERR_O ? 2 : OVERRUN_O ? 3 : 0;
      if (n > 1) begin
        checks++;
        errors++;
        $display("FAIL err_exclusive: got %0d pulses expected 1", n);
      end else if (n == 1) begin
        checks++;
        if (err_exp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err: got kind %0d expected none", code);
        end else begin
          int e;
          e = err_exp.pop_front();
          if (code != e) begin
            errors++;
            $display("FAIL err_kind: got %0d expected %0d", code, e);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX_I = b;
    wait_clk(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ PARITY_ODD_I ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    send_bit(stop_bit);
    RX_I = 1'b1;
    wait_clk(2 * BIT);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_exp.size() != 0) && n < 4000) begin
      wait_clk(1);
      n++;
    end
    check({name, "_pending"}, exp_q.size() + err_exp.size(), 0);
  endtask

  initial begin
    logic [7:0] basic [3];
    basic = '{8'h55, 8'hA3, 8'h00};
    RSTN_I  = 1'b0;
    RX_I    = 1'b1;
    READY_I = 1'b0;
`ifdef UART_RX_PARITY_EN
    PARITY_ODD_I = 1'b0;
`endif
    wait_clk(5);
    check("rst_dat",    DAT_O, 0);
    check("rst_valid",  VALID_O, 0);
    check("rst_level",  LEVEL_O, 0);
    check("rst_frame",  FRAME_ERR_O, 0);
    check("rst_parity", PARITY_ERR_O, 0);
    check("rst_ovr",    OVERRUN_O, 0);
    RSTN_I = 1'b1;
    wait_clk(20);

    READY_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(basic[i]);
      send_frame(basic[i], 1'b1, 1'b0);
    end
    drain("basic");

    READY_I = 1'b0;
    err_exp.push_back(3);
    err_exp.push_back(3);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0);
    end
    check("full_level", LEVEL_O, 16);
    check("full_valid", VALID_O, 1);
    check("full_head",  DAT_O, 8'h00);
    READY_I = 1'b1;
    drain("overrun");
    check("drained_level", LEVEL_O, 0);

    err_exp.push_back(1);
    send_frame(8'h7E, 1'b0, 1'b0);
    check("frame_nopush", LEVEL_O, 0);
    drain("frame");
    err_exp.push_back(1);
    RX_I = 1'b0;
    wait_clk(3 * FRAME);
    RX_I = 1'b1;
    wait_clk(2 * BIT);
    drain("break");
    check("break_level", LEVEL_O, 0);
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1, 1'b0);
    drain("after_break");

    RX_I = 1'b0;
    wait_clk(2);
    RX_I = 1'b1;
    wait_clk(400);
    check("glitch_level", LEVEL_O, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    drain("after_glitch");

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    drain("parity_ok");
    err_exp.push_back(2);
    send_frame(8'h01, 1'b1, 1'b1);
    drain("parity_bad");
    check("parity_level", LEVEL_O, 0);
`endif

    READY_I = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    check("pre_rst_level", LEVEL_O, 3);
    check("pre_rst_head",  DAT_O, 8'h11);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_clk(BIT / 2);
    RSTN_I = 1'b0;
    #1;
    check("mid_rst_dat",   DAT_O, 0);
    check("mid_rst_valid", VALID_O, 0);
    check("mid_rst_level", LEVEL_O, 0);
    check("mid_rst_errs",  {FRAME_ERR_O, PARITY_ERR_O, OVERRUN_O}, 0);
    RX_I = 1'b1;
    wait_clk(10);
    RSTN_I = 1'b1;
    wait_clk(2 * BIT);
    READY_I = 1'b1;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0);
    drain("after_reset");

    wait_clk(50);
    check("final_chars", exp_q.size(), 0);
    check("final_errs",  err_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Synthesizable, parametrised UART receiver; successor to the simulation-only serial listener, used on-chip behind the debug/console serial pin. Oversamples the asynchronous RX line, frames start/data/(parity)/stop, reports framing, parity and overrun errors, and buffers received characters in a FIFO drained by a valid/ready handshake. Sits between the pad-level RX_I and the peripheral bus register block.

## Interface
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: ticks per bit; even, ≥ 4.
- DATA_BITS, 8: character width, 5..8.
- FIFO_DEPTH, 16: receive buffer entries; power of two, ≥ 2.

- CLK_I  in  1  system clock, rising edge.
- RSTN_I  in  1  asynchronous active-low reset.
- RX_I  in  1  serial line, idle high, asynchronous to CLK_I.
- DAT_O  out  DATA_BITS  FIFO head character (show-ahead).
- VALID_O  out  1  FIFO non-empty.
- READY_I  in  1  consumer pops head when VALID_O && READY_I.
- LEVEL_O  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- FRAME_ERR_O  out  1  one-cycle pulse: stop bit sampled low.
- PARITY_ERR_O  out  1  one-cycle pulse: parity mismatch (0 when parity compiled out).
- OVERRUN_O  out  1  one-cycle pulse: good character dropped, FIFO full.

## Operation
- RX_I passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Free-running divider: DIV = CLK_HZ / (BAUD*OVERSAMPLE), integer floor, DIV ≥ 1 (elaboration error otherwise); emits tick every DIV cycles.
- FSM states IDLE, START, DATA, PARITY, STOP, BREAK; tick counter cnt (0..OVERSAMPLE-1), bit index idx.
- IDLE: on tick with rxs==0 -> START, cnt=0.
- START: at cnt==OVERSAMPLE/2-1 sample rxs; 0 -> DATA (cnt=0, idx=0), 1 -> IDLE (glitch, no error).
- DATA: every OVERSAMPLE ticks sample rxs into shift register, LSB first; after DATA_BITS samples -> PARITY if enabled, else STOP.
- PARITY: one sample; mismatch latched, evaluated in STOP.
- STOP: one sample. rxs==1 and no parity error -> push character (or OVERRUN_O if full), -> IDLE. rxs==1 with parity error -> PARITY_ERR_O, character discarded, -> IDLE. rxs==0 -> FRAME_ERR_O, discard, -> BREAK.
- BREAK: wait for rxs==1 on a tick, -> IDLE (break condition yields exactly one FRAME_ERR_O).
- FIFO: push and pop in same cycle when full -> both occur, no overrun; when empty -> only push (no bypass).
- Error pulses are mutually exclusive per character.

## Timing
- Reset: DAT_O=0, VALID_O=0, LEVEL_O=0, all error pulses 0, FSM IDLE, divider and FIFO pointers 0, synchronizer flops 1.
- Start-edge detection latency: 2 cycles synchronizer + up to DIV cycles tick phase.
- Samples nominally at bit centre ± one tick (divider not resynchronised to start edge).
- Push occurs in the cycle of the stop-bit sample; VALID_O/LEVEL_O update the following cycle.
- Pop: DAT_O shows next entry the cycle after VALID_O&&READY_I.
- Error pulses asserted for exactly one CLK_I cycle, the cycle after the stop-bit sample.
- Reset mid-character: character discarded, FIFO cleared, no error pulse.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present; parity type from input PARITY_ODD_I (1 odd, 0 even), one extra bit per frame.
- Undefined: PARITY state, PARITY_ODD_I and parity logic removed; PARITY_ERR_O tied 0; frame is start + DATA_BITS + stop.

## Structure
- Package uart_pkg: FSM state enum, rx_err_t (none/frame/parity/overrun), divider computation function, parameter legality checks.
- Sub-module sync_fifo (WIDTH, DEPTH): show-ahead, registered, count output; reused by future UART TX.

## Test plan
- CLK_HZ=18_432_000, BAUD=115200, OVERSAMPLE=16 (DIV=10, 160 clk/bit): send 0x55, 0xA3, 0x00 -> DAT_O sequence 0x55, 0xA3, 0x00, no error pulses.
- Hold READY_I=0, send FIFO_DEPTH+2 characters 0x00..0x11 -> LEVEL_O=16, two OVERRUN_O pulses, drain yields 0x00..0x0F.
- Stop bit forced low on 0x7E -> one FRAME_ERR_O, nothing pushed; line held low 3 frames -> still exactly one FRAME_ERR_O, next 0x31 received correctly.
- 2-clock low glitch on idle line -> no push, no error, FSM back to IDLE.
- UART_RX_PARITY_EN, PARITY_ODD_I=0: 0x01 with parity 1 -> received; parity 0 -> one PARITY_ERR_O, no push.
- RSTN_I asserted mid-data-bit with LEVEL_O=3 -> all outputs 0 immediately; next full frame 0x42 received cleanly.
